// File: rtl/acc_burst_4bit.sv
// acc_burst_4bit: sums BURST_LEN unsigned 4-bit operands per result through a
// single ripple adder, with a sticky carry-out flag and a ready/valid
// handshake on both sides.
// Build option: define ACC_SATURATE_EN to clamp the sum at 4'hF on the first
// carry-out of a burst; without it the sum wraps modulo 16.

module adder_4bit (
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic       c_in,
  output logic [3:0] sum_out,
  output logic       c_out
);

  // Full 5-bit sum; the top bit is the carry-out.
  assign {c_out, sum_out} = {1'b0, a_in} + {1'b0, b_in} + {4'b0, c_in};

endmodule

module acc_burst_4bit #(
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_sum,
  output logic       out_ovf,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LEN = 4'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] acc;
  logic [3:0] cnt;
  logic       ovf;

  logic       beat;
  logic       last_beat;
  logic [3:0] cnt_inc;
  logic [3:0] add_sum;
  logic       add_carry;
  logic [3:0] acc_load;

  // The accumulator is cleared when a result is handed off, so in IDLE it is
  // already zero and the first beat of a burst is simply 0 + in_data.
  adder_4bit u_adder (
    .a_in    (acc),
    .b_in    (in_data),
    .c_in    (1'b0),
    .sum_out (add_sum),
    .c_out   (add_carry)
  );

  assign beat      = in_valid & in_ready;
  assign cnt_inc   = cnt + 4'd1;
  // cnt is zero in IDLE, so this also catches the single-beat burst.
  assign last_beat = (cnt_inc == LEN);

`ifdef ACC_SATURATE_EN
  // Once a carry is seen the sum pins at 4'hF; any later non-zero operand
  // carries again, so the clamp holds for the rest of the burst.
  assign acc_load = add_carry ? 4'hF : add_sum;
`else
  assign acc_load = add_sum;
`endif

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs, decoded from the current state.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = last_beat ? HOLD : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_beat) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, sticky overflow and beat counter; frozen in HOLD and on gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 4'h0;
      ovf <= 1'b0;
      cnt <= 4'h0;
    end else if (beat) begin
      acc <= acc_load;
      ovf <= (state == IDLE) ? 1'b0 : (ovf | add_carry);
      cnt <= cnt_inc;
    end else if (state == HOLD && out_ready) begin
      acc <= 4'h0;
      ovf <= 1'b0;
      cnt <= 4'h0;
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_acc_burst_4bit.sv
// Directed bench for acc_burst_4bit: BURST_LEN=4 main instance plus a
// BURST_LEN=1 instance. Expected values are hand-computed per scenario.

module tb_acc_burst_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [3:0] in_data;
  logic       in_ready, out_valid, out_ovf, busy;
  logic [3:0] out_sum;

  logic       in_valid_1, out_ready_1;
  logic [3:0] in_data_1;
  logic       in_ready_1, out_valid_1, out_ovf_1, busy_1;
  logic [3:0] out_sum_1;

  int vectors    = 0;
  int miscompares = 0;
  bit busy_1_seen = 1'b0;

  always #5 clk = ~clk;

  acc_burst_4bit #(.BURST_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_ready(out_ready), .busy(busy)
  );

  acc_burst_4bit #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_data(in_data_1),
    .in_ready(in_ready_1), .out_valid(out_valid_1), .out_sum(out_sum_1),
    .out_ovf(out_ovf_1), .out_ready(out_ready_1), .busy(busy_1)
  );

  // Track whether the single-beat instance ever reports busy.
  always @(negedge clk) if (busy_1 === 1'b1) busy_1_seen = 1'b1;

  // Present one beat for one cycle, starting and ending on a falling edge.
  task automatic feed(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
    in_valid_1 = 1'b0; in_data_1 = 4'h0; out_ready_1 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (out_sum !== 4'h0) begin miscompares++; $display("FAIL reset_out_sum got %h exp 0", out_sum); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf got %b exp 0", out_ovf); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  // Beats 3,4,5,1 back-to-back: sum 13, one-cycle out_valid after beat 4.
  task automatic test_back_to_back;
    out_ready = 1'b1;
    feed(4'd3); feed(4'd4); feed(4'd5);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b exp 1", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_early_valid got %b exp 0", out_valid); end
    feed(4'd1);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
    vectors++; if (out_sum !== 4'd13) begin miscompares++; $display("FAIL b2b_sum got %0d exp 13", out_sum); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL b2b_ovf got %b exp 0", out_ovf); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_ready got %b exp 0", in_ready); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_width got %b exp 0", out_valid); end
  endtask

  // Beats 9,8,1,0: carry on the second beat.
  task automatic test_overflow;
    logic [3:0] exp_sum;
`ifdef ACC_SATURATE_EN
    exp_sum = 4'd15;
`else
    exp_sum = 4'd2;
`endif
    out_ready = 1'b1;
    feed(4'd9); feed(4'd8); feed(4'd1); feed(4'd0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %b exp 1", out_valid); end
    vectors++; if (out_sum !== exp_sum) begin miscompares++; $display("FAIL ovf_sum got %0d exp %0d", out_sum, exp_sum); end
    vectors++; if (out_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", out_ovf); end
    @(negedge clk);
  endtask

  // Beats 1,1,1,1 with 0, 1 and 3 idle cycles between them.
  task automatic test_gaps;
    int gap [3] = '{0, 1, 3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      feed(4'd1);
      for (int g = 0; g < gap[i]; g++) begin
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gap_busy beat %0d cycle %0d got %b exp 1", i, g, busy); end
        @(negedge clk);
      end
    end
    feed(4'd1);
    vectors++; if (out_sum !== 4'd4) begin miscompares++; $display("FAIL gap_sum got %0d exp 4", out_sum); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL gap_ovf got %b exp 0", out_ovf); end
    @(negedge clk);
  endtask

  // Result parked in HOLD while the producer keeps offering data.
  task automatic test_hold;
    out_ready = 1'b0;
    feed(4'd2); feed(4'd3); feed(4'd4); feed(4'd5);
    in_valid = 1'b1; in_data = 4'd9;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready cycle %0d got %b exp 0", i, in_ready); end
      vectors++; if (out_sum !== 4'd14) begin miscompares++; $display("FAIL hold_sum cycle %0d got %0d exp 14", i, out_sum); end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid cycle %0d got %b exp 1", i, out_valid); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release_valid got %b exp 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_release_busy got %b exp 0", busy); end
    @(negedge clk);
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_next_busy got %b exp 1", busy); end
    vectors++; if (out_sum !== 4'd9) begin miscompares++; $display("FAIL hold_next_acc got %0d exp 9", out_sum); end
    feed(4'd0); feed(4'd0); feed(4'd0);
    vectors++; if (out_sum !== 4'd9) begin miscompares++; $display("FAIL hold_next_sum got %0d exp 9", out_sum); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_next_valid got %b exp 1", out_valid); end
    @(negedge clk);
  endtask

  // Reset after beat 2, then a clean 2,2,2,2 burst.
  task automatic test_reset_mid_burst;
    out_ready = 1'b1;
    feed(4'd6); feed(4'd7);
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy got %b exp 0", busy); end
    vectors++; if (out_sum !== 4'h0) begin miscompares++; $display("FAIL rmid_sum got %h exp 0", out_sum); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got %b exp 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_no_pulse cycle %0d got %b exp 0", i, out_valid); end
    end
    feed(4'd2); feed(4'd2); feed(4'd2); feed(4'd2);
    vectors++; if (out_sum !== 4'd8) begin miscompares++; $display("FAIL rmid_sum_after got %0d exp 8", out_sum); end
    vectors++; if (out_ovf !== 1'b0) begin miscompares++; $display("FAIL rmid_ovf_after got %b exp 0", out_ovf); end
    @(negedge clk);
  endtask

  // BURST_LEN=1 instance: each beat is a full result.
  task automatic test_len1;
    out_ready_1 = 1'b1;
    in_valid_1  = 1'b1;
    in_data_1   = 4'd7;
    @(negedge clk);
    in_valid_1  = 1'b0;
    vectors++; if (out_valid_1 !== 1'b1) begin miscompares++; $display("FAIL len1_valid got %b exp 1", out_valid_1); end
    vectors++; if (out_sum_1 !== 4'd7) begin miscompares++; $display("FAIL len1_sum got %0d exp 7", out_sum_1); end
    @(negedge clk);
    vectors++; if (out_valid_1 !== 1'b0) begin miscompares++; $display("FAIL len1_valid_width got %b exp 0", out_valid_1); end
    vectors++; if (busy_1_seen !== 1'b0) begin miscompares++; $display("FAIL len1_busy_seen got %b exp 0", busy_1_seen); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_back_to_back;
    test_overflow;
    test_gaps;
    test_hold;
    test_reset_mid_burst;
    test_len1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/acc_burst_4bit.md
ACC_BURST_4BIT -- requirements
Module: acc_burst_4bit

Interface
REQ-001 The block SHALL have parameter BURST_LEN, default 4, giving the number of operands summed per result (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an operand is presented on in_data.
REQ-005 The block SHALL have port in_data, input, 4 bits: unsigned operand.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: out_sum and out_ovf hold a completed result.
REQ-008 The block SHALL have port out_sum, output, 4 bits: accumulated sum of the burst.
REQ-009 The block SHALL have port out_ovf, output, 1 bit: sticky carry-out seen during the burst.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port busy, output, 1 bit: a burst is partially accumulated (state ACC).

Function
REQ-012 The block SHALL perform every addition with one instance of adder_4bit: a_in = accumulator, b_in = in_data, c_in = 0; sum_out feeds the accumulator and c_out feeds the overflow flag.
REQ-013 A beat SHALL transfer on a rising clk edge where in_valid=1 and in_ready=1; in_valid=0 cycles (gaps) SHALL leave all state unchanged.
REQ-014 The FSM SHALL have states IDLE, ACC and HOLD.
REQ-015 In IDLE: in_ready=1, out_valid=0, busy=0; on a beat, acc <= 0 + in_data, ovf <= 0, cnt <= 1; next state is HOLD if BURST_LEN=1, else ACC.
REQ-016 In ACC: in_ready=1, busy=1; on a beat, acc <= adder sum, ovf <= ovf | carry-out, cnt <= cnt+1; when the accepted beat is number BURST_LEN, next state is HOLD.
REQ-017 In HOLD: out_valid=1, in_ready=0, busy=0; out_sum and out_ovf SHALL stay stable until the cycle in which out_ready=1, after which next state is IDLE.
REQ-018 Latency: out_valid SHALL rise the cycle after the final beat is accepted.
REQ-019 The block SHALL NOT accept input while in HOLD, including a cycle with simultaneous out_ready=1 and in_valid=1; the next burst starts no earlier than the following cycle.
REQ-020 Without saturation, addition SHALL wrap modulo 16.
REQ-021 out_sum SHALL drive the accumulator register directly; out_ovf SHALL drive the sticky flag directly.
REQ-022 in_data SHALL be ignored whenever in_ready=0.

Reset
REQ-023 When rst=1, the block SHALL asynchronously force: state IDLE, acc=0, ovf=0, cnt=0, out_valid=0, busy=0, out_sum=4'h0, out_ovf=0; in_ready SHALL be 1 once rst=0.
REQ-024 Reset mid-burst or in HOLD SHALL discard the partial or pending result with no out_valid pulse.

Configuration
REQ-025 Macro ACC_SATURATE_EN, when defined: on any beat whose carry-out is 1, acc SHALL load 4'hF and remain at 4'hF for the rest of the burst; out_ovf still SHALL be set.
REQ-026 Without ACC_SATURATE_EN: wrap behaviour per REQ-020; no saturation logic SHALL be present.

Verification
REQ-027 With BURST_LEN=4, beats 3,4,5,1 back-to-back, out_ready=1 -> out_sum=13, out_ovf=0, out_valid high for exactly one cycle, one cycle after beat 4.
REQ-028 With beats 9,8,1,0 -> without macro: out_sum=2, out_ovf=1; with ACC_SATURATE_EN: out_sum=15, out_ovf=1.
REQ-029 Beats 1,1,1,1 with in_valid gaps of 0-3 cycles between them -> out_sum=4, out_ovf=0, and busy=1 throughout the gaps.
REQ-030 Result in HOLD with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_sum stable, no beat consumed; out_ready=1 -> IDLE next cycle, then the next beat accepted.
REQ-031 rst asserted after beat 2 of a burst -> outputs at reset values immediately; a fresh burst 2,2,2,2 afterwards -> out_sum=8, out_ovf=0.
REQ-032 With BURST_LEN=1, beat 7 -> out_sum=7, out_valid high on the next cycle, busy never 1.
